dbg_dump_streamer: RTL

Debug-side companion to the 5-stage MIPS pipeline: captures a snapshot of the sixteen watched architectural registers (t0–t7, s0–s7), the 7-bit PC and the two watched memory words on request, then streams them out as a framed 20-word packet over a valid/ready handshake. It sits beside `main` and feeds a host-side logger or UART bridge, so register state can leave the chip instead of being read through simulator probes.

---
 rtl/dbg_pkg.sv | 16 +
 rtl/dbg_snap_bank.sv | 65 ++++++
 rtl/dbg_dump_streamer.sv | 132 +++++++++++++
 3 files changed

// File: rtl/dbg_pkg.sv
// Shared constants and types for the debug dump streamer.
package dbg_pkg;

    // Upper half of word 0, tags the start of every packet.
    localparam logic [15:0] HDR = 16'hDB60;

    // Packet: header, 16 registers, 2 memory words, checksum.
    localparam int PKT_LEN = 20;
    localparam logic [4:0] CSUM_IDX = 5'(PKT_LEN - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/dbg_snap_bank.sv
// Snapshot capture registers and the word-index to packet-word mux.
module dbg_snap_bank
    import dbg_pkg::*;
#(
    parameter int W    = 32,
    parameter int NREG = 16,
    parameter int PCW  = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_cap_en,
    input  logic [NREG*W-1:0] i_regs_flat,
    input  logic [PCW-1:0]    i_pc,
    input  logic [W-1:0]      i_mem1,
    input  logic [W-1:0]      i_mem2,
    input  logic [4:0]        i_idx,
    input  logic [W-1:0]      i_csum,
    output logic [W-1:0]      o_word
);

    localparam logic [4:0] IDX_MEM1 = 5'(NREG + 1);
    localparam logic [4:0] IDX_MEM2 = 5'(NREG + 2);

    logic [NREG*W-1:0] r_regs;
    logic [PCW-1:0]    r_pc;
    logic [W-1:0]      r_mem1;
    logic [W-1:0]      r_mem2;

    // Capture all watched state in one edge so the packet is a coherent snapshot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_regs <= '0;
            r_pc   <= '0;
            r_mem1 <= '0;
            r_mem2 <= '0;
        end else if (i_cap_en) begin
            r_regs <= i_regs_flat;
            r_pc   <= i_pc;
            r_mem1 <= i_mem1;
            r_mem2 <= i_mem2;
        end
    end

    // Select the packet word for the current index; checksum comes from the top.
    always_comb begin
        o_word = '0;
        if (i_idx == 5'd0) begin
            o_word[W-1 -: 16] = HDR;
            o_word[PCW-1:0]   = r_pc;
        end else if (i_idx == IDX_MEM1) begin
            o_word = r_mem1;
        end else if (i_idx == IDX_MEM2) begin
            o_word = r_mem2;
        end else if (i_idx == CSUM_IDX) begin
            o_word = i_csum;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (i_idx == 5'(i + 1)) begin
                    o_word = r_regs[i*W +: W];
                end
            end
        end
    end

endmodule

// File: rtl/dbg_dump_streamer.sv
// Snapshot-and-stream debug dump: captures watched registers, PC and two
// memory words on request and sends them as a 20-word framed packet.
//
//   state | meaning
//   IDLE  | no packet pending; snap_req captures and starts a packet
//   SEND  | packet in flight, out_valid high, extra requests are dropped
module dbg_dump_streamer
    import dbg_pkg::*;
#(
    parameter int W    = 32,
    parameter int NREG = 16,
    parameter int PCW  = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              snap_req,
    input  logic [NREG*W-1:0] regs_flat,
    input  logic [PCW-1:0]    pc,
    input  logic [W-1:0]      mem1,
    input  logic [W-1:0]      mem2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W-1:0]      out_data,
    output logic [4:0]        out_idx,
    output logic              out_last,
    output logic              busy,
    output logic [7:0]        drop_cnt
);

    state_t         r_state;
    state_t         w_next_state;
    logic [4:0]     r_idx;
    logic [W-1:0]   r_csum;
    logic [7:0]     r_drop;
    logic [W-1:0]   w_word;
    logic           w_busy;
    logic           w_xfer;
    logic           w_at_last;
    logic           w_end;
    logic           w_cap;
    logic           w_drop;

    assign w_busy    = (r_state == SEND);
    assign w_xfer    = w_busy & out_ready;
    assign w_at_last = (r_idx == CSUM_IDX);
    assign w_end     = w_xfer & w_at_last;

    // Next state plus capture/drop decisions; a request on the last transfer chains.
    always_comb begin
        w_next_state = r_state;
        w_cap        = 1'b0;
        w_drop       = 1'b0;
        case (r_state)
            IDLE: begin
                if (snap_req) begin
                    w_cap        = 1'b1;
                    w_next_state = SEND;
                end
            end
            SEND: begin
                if (w_end) begin
                    if (snap_req) begin
                        w_cap = 1'b1;
                    end else begin
                        w_next_state = IDLE;
                    end
                end else if (snap_req) begin
                    w_drop = 1'b1;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Word index and running checksum; both restart with every new snapshot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx  <= '0;
            r_csum <= '0;
        end else if (w_cap || w_end) begin
            r_idx  <= '0;
            r_csum <= '0;
        end else if (w_xfer) begin
            r_idx  <= r_idx + 5'd1;
            r_csum <= r_csum ^ w_word;
        end
    end

    // Saturating count of requests that arrived while a packet was in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop <= '0;
        end else if (w_drop && (r_drop != 8'hFF)) begin
            r_drop <= r_drop + 8'd1;
        end
    end

    dbg_snap_bank #(
        .W    (W),
        .NREG (NREG),
        .PCW  (PCW)
    ) u_snap_bank (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_cap_en    (w_cap),
        .i_regs_flat (regs_flat),
        .i_pc        (pc),
        .i_mem1      (mem1),
        .i_mem2      (mem2),
        .i_idx       (r_idx),
        .i_csum      (r_csum),
        .o_word      (w_word)
    );

    // Data is forced to zero outside a packet so idle/reset shows a clean bus.
    assign out_data  = w_busy ? w_word : '0;
    assign out_valid = w_busy;
    assign out_idx   = r_idx;
    assign out_last  = w_busy & w_at_last;
    assign busy      = w_busy;
    assign drop_cnt  = r_drop;

endmodule
